// File: rtl/a_regfile_sb_pkg.sv
// Shared defaults, A0 read constants and result-chain slot layout for a_regfile_sb.
// A_REGFILE_WB_CHECK_EN (see a_regfile_sb.sv) adds writeback protocol checking.
package a_regfile_sb_pkg;

  localparam int WIDTH_DEF    = 24;
  localparam int DEPTH_DEF    = 8;
  localparam int LOGDEPTH_DEF = 3;
  localparam int MAXLAT_DEF   = 8;
  localparam int LOGLAT_DEF   = 4;

  // Values returned in place of A0 on the j/h and k read ports
  localparam int A0_J_VAL = 0;
  localparam int A0_H_VAL = 0;
  localparam int A0_K_VAL = 1;

  // Slot record is {valid, addr}: valid is the MSB, addr fills the low bits
  function automatic int slot_w(input int logdepth);
    return logdepth + 1;
  endfunction

endpackage

// File: rtl/a_result_chain.sv
// Functional-unit result timing chain: slot[n] is the writeback due n cycles from now.
// Shifts toward slot[0] every edge; an insert overrides the shifted-in value.
module a_result_chain
  import a_regfile_sb_pkg::*;
#(
  parameter int LOGDEPTH = LOGDEPTH_DEF,
  parameter int MAXLAT   = MAXLAT_DEF,
  parameter int LOGLAT   = LOGLAT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_ins_en,
  input  logic [LOGLAT-1:0]   i_ins_idx,
  input  logic [LOGDEPTH-1:0] i_ins_addr,
  input  logic [LOGLAT-1:0]   i_query_lat,
  output logic                o_query_hit,
  output logic                o_head_valid,
  output logic [LOGDEPTH-1:0] o_head_addr
);

  localparam int SW = slot_w(LOGDEPTH);

  logic [SW-1:0] r_slot [MAXLAT];
  logic [SW-1:0] w_next [MAXLAT];

  always_comb begin
    for (int n = 0; n < MAXLAT - 1; n++) begin
      w_next[n] = r_slot[n+1];
    end
    w_next[MAXLAT-1] = '0;
    for (int n = 0; n < MAXLAT; n++) begin
      if (i_ins_en && i_ins_idx == LOGLAT'(n)) begin
        w_next[n] = {1'b1, i_ins_addr};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < MAXLAT; n++) begin
        r_slot[n] <= '0;
      end
    end else begin
      for (int n = 0; n < MAXLAT; n++) begin
        r_slot[n] <= w_next[n];
      end
    end
  end

  // Latencies at or beyond MAXLAT match no slot, so they never report a conflict
  always_comb begin
    o_query_hit = 1'b0;
    for (int n = 0; n < MAXLAT; n++) begin
      if (i_query_lat == LOGLAT'(n)) begin
        o_query_hit = r_slot[n][SW-1];
      end
    end
  end

  assign o_head_valid = r_slot[0][SW-1];
  assign o_head_addr  = r_slot[0][LOGDEPTH-1:0];

endmodule

// File: rtl/a_regfile_sb.sv
// A-register file with write-first bypass, A0 branch flags, reservation scoreboard
// and result timing chain. Define A_REGFILE_WB_CHECK_EN to build the writeback checker.
module a_regfile_sb
  import a_regfile_sb_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int LOGDEPTH = LOGDEPTH_DEF,
  parameter int MAXLAT   = MAXLAT_DEF,
  parameter int LOGLAT   = LOGLAT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LOGDEPTH-1:0] i_j_addr,
  input  logic [LOGDEPTH-1:0] i_k_addr,
  input  logic [LOGDEPTH-1:0] i_i_addr,
  input  logic [LOGDEPTH-1:0] i_h_addr,
  output logic [WIDTH-1:0]    o_j_data,
  output logic [WIDTH-1:0]    o_k_data,
  output logic [WIDTH-1:0]    o_i_data,
  output logic [WIDTH-1:0]    o_h_data,
  output logic                o_j_busy,
  output logic                o_k_busy,
  output logic                o_i_busy,
  output logic                o_h_busy,
  input  logic [LOGDEPTH-1:0] i_ex_addr,
  output logic [WIDTH-1:0]    o_ex_data,
  output logic [WIDTH-1:0]    o_a0_data,
  output logic                o_a0_pos,
  output logic                o_a0_neg,
  output logic                o_a0_zero,
  output logic                o_a0_nzero,
  input  logic                i_iss_en,
  input  logic [LOGDEPTH-1:0] i_iss_addr,
  input  logic [LOGLAT-1:0]   i_iss_lat,
  output logic                o_iss_ok,
  input  logic                i_wb_en,
  input  logic [LOGDEPTH-1:0] i_wb_addr,
  input  logic [WIDTH-1:0]    i_wb_data,
  output logic [DEPTH-1:0]    o_busy,
  output logic                o_wb_err
);

  logic [WIDTH-1:0]    r_regs [DEPTH];
  logic [DEPTH-1:0]    r_busy;
  logic                w_slot_hit;
  logic                w_head_valid;
  logic [LOGDEPTH-1:0] w_head_addr;
  logic                w_lat_ok;
  logic                w_issue;
  logic [LOGLAT-1:0]   w_ins_idx;
  logic [DEPTH-1:0]    w_set_mask;
  logic [DEPTH-1:0]    w_clr_mask;
  logic [WIDTH-1:0]    w_a0;

  function automatic logic [WIDTH-1:0] f_read(input logic [LOGDEPTH-1:0] a,
                                              input logic sub_a0,
                                              input logic [WIDTH-1:0] a0_val);
    logic [WIDTH-1:0] v;
    if (i_wb_en && a == i_wb_addr) v = i_wb_data;
    else if (sub_a0 && a == '0)    v = a0_val;
    else                           v = r_regs[a];
    return v;
  endfunction

  always_comb begin
    o_j_data = f_read(i_j_addr, 1'b1, WIDTH'(A0_J_VAL));
    o_k_data = f_read(i_k_addr, 1'b1, WIDTH'(A0_K_VAL));
    o_i_data = f_read(i_i_addr, 1'b0, '0);
    o_h_data = f_read(i_h_addr, 1'b1, WIDTH'(A0_H_VAL));
  end

  assign o_j_busy  = r_busy[i_j_addr];
  assign o_k_busy  = r_busy[i_k_addr];
  assign o_i_busy  = r_busy[i_i_addr];
  assign o_h_busy  = r_busy[i_h_addr];
  assign o_busy    = r_busy;
  assign o_ex_data = r_regs[i_ex_addr];

  assign w_a0       = r_regs[0];
  assign o_a0_data  = w_a0;
  assign o_a0_neg   = w_a0[WIDTH-1];
  assign o_a0_pos   = ~w_a0[WIDTH-1];
  assign o_a0_zero  = (w_a0 == '0);
  assign o_a0_nzero = (w_a0 != '0);

  a_result_chain #(
    .LOGDEPTH (LOGDEPTH),
    .MAXLAT   (MAXLAT),
    .LOGLAT   (LOGLAT)
  ) u_chain (
    .clk          (clk),
    .rst          (rst),
    .i_ins_en     (w_issue),
    .i_ins_idx    (w_ins_idx),
    .i_ins_addr   (i_iss_addr),
    .i_query_lat  (i_iss_lat),
    .o_query_hit  (w_slot_hit),
    .o_head_valid (w_head_valid),
    .o_head_addr  (w_head_addr)
  );

  // slot[lat] moves into slot[lat-1] at this edge, which is where the new entry would land
  assign w_lat_ok  = (i_iss_lat != '0) && (i_iss_lat <= LOGLAT'(MAXLAT));
  assign o_iss_ok  = w_lat_ok && !r_busy[i_iss_addr] && !w_slot_hit;
  assign w_issue   = i_iss_en && o_iss_ok;
  assign w_ins_idx = i_iss_lat - LOGLAT'(1);

  assign w_set_mask = w_issue      ? (DEPTH'(1) << i_iss_addr)  : '0;
  assign w_clr_mask = w_head_valid ? (DEPTH'(1) << w_head_addr) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < DEPTH; d++) begin
        r_regs[d] <= '0;
      end
    end else if (i_wb_en) begin
      r_regs[i_wb_addr] <= i_wb_data;
    end
  end

`ifdef A_REGFILE_WB_CHECK_EN
  logic w_wb_mis;
  logic r_wb_err;

  // Any disagreement between the expected slot and the actual writeback
  assign w_wb_mis = i_wb_en ? (!w_head_valid || i_wb_addr != w_head_addr) : w_head_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_err <= 1'b0;
    end else begin
      r_wb_err <= w_wb_mis;
    end
  end

  assign o_wb_err = r_wb_err;
`else
  assign o_wb_err = 1'b0;
`endif

endmodule
